sram_1rw_master: RTL and testbench

- Host-side initiator for the single-port 32x128 SRAM macro (`SRAM_32x128_1rw` pin set: csb0/web0/addr0/din0/dout0).
- Converts a valid/ready request stream into correctly timed active-low macro strobes.
- Captures read data after a configurable latency and returns it on a valid/ready response channel.
- Sits between bus/fabric logic and the SRAM macro; the only block allowed to drive the macro pins.

---
 rtl/sram_1rw_master_pkg.sv | 24 ++
 rtl/sram_1rw_master_bist.sv | 75 +++++++
 rtl/sram_1rw_master.sv | 218 +++++++++++++++++++++
 tb/tb_sram_1rw_master.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_1rw_master_pkg.sv
// Shared types and constants for the single-port SRAM host master.
// State codes, default geometry, and the BIST pattern bit function.
package sram_1rw_master_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 7;
  localparam logic [31:0] BIST_XOR       = 32'hA5A5A5A5;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_CMD     = 3'd1;
  localparam state_t S_WAIT    = 3'd2;
  localparam state_t S_RESP    = 3'd3;
  localparam state_t S_BIST_WR = 3'd4;
  localparam state_t S_BIST_RD = 3'd5;

  // Bit idx of the address replicated across the word, XORed with BIST_XOR.
  function automatic logic bist_pattern_bit(input logic [31:0] a,
                                            input int unsigned idx,
                                            input int unsigned aw);
    return a[5'(idx % aw)] ^ BIST_XOR[5'(idx % 32)];
  endfunction

endpackage

// File: rtl/sram_1rw_master_bist.sv
// BIST sequencer: address counter, write/read phase, pattern, sticky fail.
// Built only when SRAM_1RW_MASTER_BIST_EN is defined.
module sram_1rw_master_bist
  import sram_1rw_master_pkg::*;
#(
  parameter int unsigned DW = DEF_DATA_WIDTH,
  parameter int unsigned AW = DEF_ADDR_WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          adv_i,
  input  logic          cmp_i,
  input  logic [DW-1:0] rdata_i,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] pat_o,
  output logic          last_o,
  output logic          done_o,
  output logic          fail_o
);

  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;

  assign addr_o = addr_q;
  assign last_o = &addr_q;
  assign done_o = done_q;
  assign fail_o = fail_q;

  always_comb begin
    for (int unsigned i = 0; i < DW; i++) begin
      pat_o[i] = bist_pattern_bit(32'(addr_q), i, AW);
    end
  end

  always_comb begin
    addr_d = addr_q;
    rd_d   = rd_q;
    done_d = done_q;
    fail_d = fail_q;
    if (start_i) begin
      addr_d = '0;
      rd_d   = 1'b0;
      done_d = 1'b0;
      fail_d = 1'b0;
    end else begin
      if (cmp_i && (rdata_i != pat_o)) fail_d = 1'b1;
      if (adv_i) begin
        // Address wraps to 0 after the last word, ready for the next phase.
        addr_d = addr_q + 1'b1;
        if (last_o) begin
          if (rd_q) done_d = 1'b1;
          rd_d = ~rd_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      rd_q   <= rd_d;
      done_q <= done_d;
      fail_q <= fail_d;
    end
  end

endmodule

// File: rtl/sram_1rw_master.sv
// Host-side initiator for the 1RW SRAM macro: request -> registered strobes,
// read capture after READ_LAT, response handshake. BIST via SRAM_1RW_MASTER_BIST_EN.
module sram_1rw_master
  import sram_1rw_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
`ifdef SRAM_1RW_MASTER_BIST_EN
  input  logic                  bist_start,
  output logic                  bist_done,
  output logic                  bist_fail,
`endif
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 1);

  state_t                state_q, state_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rdy_q, rdy_d;
  logic                  rspv_q, rspv_d;
  logic [2:0]            lat_q, lat_d;

`ifdef SRAM_1RW_MASTER_BIST_EN
  logic                  bist_mode_q, bist_mode_d;
  logic                  bist_go, bist_adv, bist_cmp, bist_last;
  logic [ADDR_WIDTH-1:0] bist_addr;
  logic [DATA_WIDTH-1:0] bist_pat;

  assign bist_go   = (state_q == S_IDLE) && bist_start;
  // A start request pre-empts a same-cycle host request so it is not dropped.
  assign req_ready = rdy_q & ~bist_start;

  sram_1rw_master_bist #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH)
  ) u_bist (
    .clk_i   (clk0),
    .rst_i   (rst0),
    .start_i (bist_go),
    .adv_i   (bist_adv),
    .cmp_i   (bist_cmp),
    .rdata_i (dout0),
    .addr_o  (bist_addr),
    .pat_o   (bist_pat),
    .last_o  (bist_last),
    .done_o  (bist_done),
    .fail_o  (bist_fail)
  );
`else
  assign req_ready = rdy_q;
`endif

  assign csb0      = csb_q;
  assign web0      = web_q;
  assign addr0     = addr_q;
  assign din0      = din_q;
  assign rsp_valid = rspv_q;
  assign rsp_rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    rdy_d   = 1'b0;
    rspv_d  = rspv_q;
    lat_d   = lat_q;
`ifdef SRAM_1RW_MASTER_BIST_EN
    bist_mode_d = bist_mode_q;
    bist_adv    = 1'b0;
    bist_cmp    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        rdy_d = 1'b1;
`ifdef SRAM_1RW_MASTER_BIST_EN
        if (bist_start) begin
          rdy_d       = 1'b0;
          bist_mode_d = 1'b1;
          state_d     = S_BIST_WR;
        end else
`endif
        if (req_valid && req_ready) begin
          state_d = S_CMD;
          rdy_d   = 1'b0;
          csb_d   = 1'b0;
          web_d   = ~req_we;
          we_d    = req_we;
          addr_d  = req_addr;
          if (req_we) din_d = req_wdata;
        end
      end
      S_CMD: begin
        lat_d = '0;
        if (!we_q) begin
          state_d = S_WAIT;
        end
`ifdef SRAM_1RW_MASTER_BIST_EN
        else if (bist_mode_q) begin
          bist_adv = 1'b1;
          state_d  = bist_last ? S_BIST_RD : S_BIST_WR;
        end
`endif
        else begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
        end
      end
      S_WAIT: begin
        lat_d = lat_q + 3'd1;
        if (lat_q == LAT_LAST) begin
          lat_d = '0;
`ifdef SRAM_1RW_MASTER_BIST_EN
          if (bist_mode_q) begin
            bist_cmp = 1'b1;
            bist_adv = 1'b1;
            if (bist_last) begin
              state_d     = S_IDLE;
              rdy_d       = 1'b1;
              bist_mode_d = 1'b0;
            end else begin
              state_d = S_BIST_RD;
            end
          end else
`endif
          begin
            rdata_d = dout0;
            rspv_d  = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rspv_d  = 1'b0;
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
`ifdef SRAM_1RW_MASTER_BIST_EN
      // BIST reuses CMD/WAIT; these states only issue the next strobe.
      S_BIST_WR: begin
        csb_d   = 1'b0;
        web_d   = 1'b0;
        we_d    = 1'b1;
        addr_d  = bist_addr;
        din_d   = bist_pat;
        state_d = S_CMD;
      end
      S_BIST_RD: begin
        csb_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = bist_addr;
        state_d = S_CMD;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_q <= S_IDLE;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      rspv_q  <= 1'b0;
      lat_q   <= '0;
`ifdef SRAM_1RW_MASTER_BIST_EN
      bist_mode_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      rspv_q  <= rspv_d;
      lat_q   <= lat_d;
`ifdef SRAM_1RW_MASTER_BIST_EN
      bist_mode_q <= bist_mode_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_1rw_master.sv
// Scoreboard bench for sram_1rw_master (READ_LAT=1 and READ_LAT=3 instances).
// Exercises BIST too when SRAM_1RW_MASTER_BIST_EN is defined.
module tb_sram_1rw_master;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 7;
  localparam int unsigned RL = 1;

  logic clk0 = 1'b0;
  logic rst0;
  always #5 clk0 = ~clk0;

  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          csb0, web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0, dout0;

  logic          r3_valid, r3_ready, r3_we, r3_rsp_valid, r3_rsp_ready, r3_csb, r3_web;
  logic [AW-1:0] r3_addr, r3_addr0;
  logic [DW-1:0] r3_wdata, r3_rdata, r3_din, r3_dout;

`ifdef SRAM_1RW_MASTER_BIST_EN
  logic bist_start, bist_done, bist_fail, r3_bdone, r3_bfail;
`endif

  sram_1rw_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(RL)) dut (
    .clk0(clk0), .rst0(rst0), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0),
`ifdef SRAM_1RW_MASTER_BIST_EN
    .bist_start(bist_start), .bist_done(bist_done), .bist_fail(bist_fail),
`endif
    .dout0(dout0)
  );

  sram_1rw_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(3)) dut3 (
    .clk0(clk0), .rst0(rst0), .req_valid(r3_valid), .req_ready(r3_ready),
    .req_we(r3_we), .req_addr(r3_addr), .req_wdata(r3_wdata),
    .rsp_valid(r3_rsp_valid), .rsp_ready(r3_rsp_ready), .rsp_rdata(r3_rdata),
    .csb0(r3_csb), .web0(r3_web), .addr0(r3_addr0), .din0(r3_din),
`ifdef SRAM_1RW_MASTER_BIST_EN
    .bist_start(1'b0), .bist_done(r3_bdone), .bist_fail(r3_bfail),
`endif
    .dout0(r3_dout)
  );

  // Macro models: latency 1 for dut, latency 3 (two extra stages) for dut3.
  logic [DW-1:0] mem  [0:127];
  logic [DW-1:0] mem3 [0:127];
  logic          corrupt;
  always @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) mem[addr0] <= din0;
      else dout0 <= mem[addr0] ^ ((corrupt && addr0 == 7'd5) ? 32'h0000_0100 : 32'h0);
    end
  end
  logic [DW-1:0] s0, s1, s2;
  always @(posedge clk0) begin
    if (!r3_csb) begin
      if (!r3_web) mem3[r3_addr0] <= r3_din;
      else s0 <= mem3[r3_addr0];
    end
    s1 <= s0;
    s2 <= s1;
  end
  assign r3_dout = s2;

  int unsigned   total = 0, bad = 0;
  int unsigned   cyc = 0;
  always @(posedge clk0) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [DW-1:0] ref_mem [0:127];
  logic [DW-1:0] exp_q [$];
  int unsigned   lat_exp [$];
  int unsigned   csb_lo [$];
  int unsigned   web_lo = 0, rsp_cnt = 0, hs_edge = 0, acc_cyc = 0;
  logic          rspv_prev = 1'b0;

  // Response monitor: latency on rise, data on handshake, strobe bookkeeping.
  always @(negedge clk0) begin
    if (!rst0) begin
      if (rsp_valid && !rspv_prev) begin
        if (lat_exp.size() == 0) check_val("stale_rsp", 32'(rsp_valid), 32'd0);
        else check_val("rsp_lat", cyc, lat_exp.pop_front());
      end
      if (rsp_valid && rsp_ready) begin
        hs_edge = cyc + 1;
        rsp_cnt++;
        if (exp_q.size() == 0) check_val("rsp_extra", 32'(rsp_valid), 32'd0);
        else check_val("rsp_data", rsp_rdata, exp_q.pop_front());
      end
      if (!csb0) begin
        check_val("rdy_in_cmd", 32'(req_ready), 32'd0);
        csb_lo.push_back(cyc);
        if (!web0) web_lo++;
      end
    end
    rspv_prev = rsp_valid;
  end

  task automatic req_start(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic req_wait();
    int unsigned n = 0;
    do begin @(negedge clk0); n++; end while (!req_ready && n < 40);
    check_val("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk0); #1;
    acc_cyc = cyc;
    if (req_we) ref_mem[req_addr] = req_wdata;
    else begin
      exp_q.push_back(ref_mem[req_addr]);
      lat_exp.push_back(acc_cyc + RL + 1);
    end
    req_valid = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_start(we, a, d);
    req_wait();
  endtask

  task automatic r3_wait(output int unsigned acc);
    int unsigned n = 0;
    do begin @(negedge clk0); n++; end while (!r3_ready && n < 40);
    check_val("r3_ready", 32'(r3_ready), 32'd1);
    @(posedge clk0); #1;
    acc = cyc;
    r3_valid = 1'b0;
  endtask

`ifdef SRAM_1RW_MASTER_BIST_EN
  function automatic logic [31:0] tb_pat(input logic [6:0] a);
    logic [34:0] rep;
    rep = {a, a, a, a, a};
    return rep[31:0] ^ 32'hA5A5A5A5;
  endfunction
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, acc3, vcnt;
    rst0 = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; corrupt = 1'b0;
    r3_valid = 1'b0; r3_we = 1'b0; r3_addr = '0; r3_wdata = '0; r3_rsp_ready = 1'b1;
`ifdef SRAM_1RW_MASTER_BIST_EN
    bist_start = 1'b0;
`endif
    repeat (3) @(posedge clk0);
    #1;
    check_val("rst_csb", 32'(csb0), 32'd1);
    check_val("rst_web", 32'(web0), 32'd1);
    check_val("rst_addr", 32'(addr0), 32'd0);
    check_val("rst_din", din0, 32'd0);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_rspv", 32'(rsp_valid), 32'd0);
    check_val("rst_rdata", rsp_rdata, 32'd0);
`ifdef SRAM_1RW_MASTER_BIST_EN
    check_val("rst_bdone", 32'(bist_done), 32'd0);
    check_val("rst_bfail", 32'(bist_fail), 32'd0);
`endif
    rst0 = 1'b0;
    #1 check_val("ready_after_rel", 32'(req_ready), 32'd0);
    @(posedge clk0); #1;
    check_val("ready_first_cyc", 32'(req_ready), 32'd1);

    // Write then read addr 10.
    csb_lo.delete(); web_lo = 0;
    do_req(1'b1, 7'd10, 32'hFACECAFE);
    do_req(1'b0, 7'd10, 32'h0);
    repeat (4) @(posedge clk0);
    #1;
    check_val("t1_csb_pulses", csb_lo.size(), 32'd2);
    check_val("t1_web_pulses", web_lo, 32'd1);
    if (csb_lo.size() == 2) check_val("t1_csb_gap", csb_lo[1] - csb_lo[0], 32'd2);

    // Three back-to-back writes with req_valid held.
    csb_lo.delete(); web_lo = 0;
    for (int unsigned k = 0; k < 3; k++) do_req(1'b1, 7'd1, 32'hDEADBEEF);
    repeat (3) @(posedge clk0);
    #1;
    check_val("t2_csb_pulses", csb_lo.size(), 32'd3);
    check_val("t2_web_pulses", web_lo, 32'd3);
    if (csb_lo.size() == 3) begin
      check_val("t2_gap0", csb_lo[1] - csb_lo[0], 32'd2);
      check_val("t2_gap1", csb_lo[2] - csb_lo[1], 32'd2);
    end

    // Read with consumer stalled 5 cycles and a request queued behind it.
    rsp_ready = 1'b0;
    do_req(1'b0, 7'd10, 32'h0);
    req_start(1'b0, 7'd1, 32'h0);
    n = 0;
    do begin @(posedge clk0); #1; n++; end while (!rsp_valid && n < 10);
    for (int unsigned k = 0; k < 5; k++) begin
      check_val("t3_rspv_hold", 32'(rsp_valid), 32'd1);
      check_val("t3_rdata_hold", rsp_rdata, 32'hFACECAFE);
      check_val("t3_ready_low", 32'(req_ready), 32'd0);
      if (k < 4) begin @(posedge clk0); #1; end
    end
    rsp_ready = 1'b1;
    req_wait();
    check_val("t3_queued_acc", acc_cyc, hs_edge + 1);
    repeat (4) @(posedge clk0);
    #1;

    // Reset while a read is waiting for data.
    do_req(1'b0, 7'd10, 32'h0);
    @(posedge clk0); #1;
    rst0 = 1'b1;
    #1;
    exp_q.delete();
    lat_exp.delete();
    check_val("t4_csb", 32'(csb0), 32'd1);
    check_val("t4_web", 32'(web0), 32'd1);
    check_val("t4_rspv", 32'(rsp_valid), 32'd0);
    @(posedge clk0); #1;
    rst0 = 1'b0;
    check_val("t4_ready_rel", 32'(req_ready), 32'd0);
    @(posedge clk0); #1;
    check_val("t4_ready_next", 32'(req_ready), 32'd1);
    vcnt = 0;
    for (int unsigned k = 0; k < 6; k++) begin
      @(posedge clk0); #1;
      if (rsp_valid) vcnt++;
    end
    check_val("t4_no_stale", vcnt, 32'd0);

    // READ_LAT=3 instance: write then read addr 127.
    r3_valid = 1'b1; r3_we = 1'b1; r3_addr = 7'd127; r3_wdata = 32'h12345678;
    r3_wait(acc3);
    r3_valid = 1'b1; r3_we = 1'b0;
    r3_wait(acc3);
    n = 0;
    do begin @(negedge clk0); n++; end while (!r3_rsp_valid && n < 12);
    check_val("r3_lat", cyc - acc3, 32'd4);
    check_val("r3_rdata", r3_rdata, 32'h12345678);
    @(posedge clk0); #1;
    check_val("r3_rspv_drop", 32'(r3_rsp_valid), 32'd0);

`ifdef SRAM_1RW_MASTER_BIST_EN
    for (int unsigned run = 0; run < 2; run++) begin
      corrupt = (run == 1);
      bist_start = 1'b1;
      @(posedge clk0); #1;
      bist_start = 1'b0;
      check_val("bist_done_clr", 32'(bist_done), 32'd0);
      check_val("bist_fail_clr", 32'(bist_fail), 32'd0);
      n = 0; vcnt = 0;
      while (!bist_done && n < 128 * 2 + 128 * (RL + 2) + 4) begin
        @(posedge clk0); #1;
        n++;
        if (!bist_done && req_ready) vcnt++;
      end
      check_val("bist_done", 32'(bist_done), 32'd1);
      check_val("bist_fail", 32'(bist_fail), 32'(run == 1));
      check_val("bist_ready_low", vcnt, 32'd0);
      if (run == 0) begin
        check_val("bist_mem0", mem[0], tb_pat(7'd0));
        check_val("bist_mem77", mem[77], tb_pat(7'd77));
        check_val("bist_mem127", mem[127], tb_pat(7'd127));
      end
      repeat (3) @(posedge clk0);
      #1;
    end
    corrupt = 1'b0;
`endif

    check_val("rsp_count", rsp_cnt, 32'd3);
    check_val("exp_q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
